// File: rtl/inst_rom_loader.sv
// Instruction RAM that answers the core's fetch port combinationally and is filled by a
// byte-serial loader while the core is held in reset.
module inst_rom_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter bit          BOOT_RUN  = 1'b0,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              ld_start_i,
    input  logic [ADDR_W:0]   ld_len_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    output logic              ld_busy_o,
    output logic              ld_done_o,
    output logic              ld_err_o,
    output logic              cpu_rst_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len;
    logic [1:0]         byte_cnt;
    logic [ADDR_W-1:0]  word_ptr;
    logic [23:0]        byte_buf;
    logic [31:0]        mem [DEPTH];

    logic accept_c;
    logic wr_en_c;
    logic last_word_c;
    logic len_ok_c;
    logic unused_addr_lsb_c;

    assign accept_c          = ld_valid_i & ld_ready_o & (state == S_LOAD);
    assign wr_en_c           = accept_c & (byte_cnt == 2'd3);
    assign last_word_c       = (LEN_W'(word_ptr) == (len - LEN_W'(1)));
    assign len_ok_c          = (ld_len_i != '0) && (ld_len_i <= LEN_W'(DEPTH));
    assign unused_addr_lsb_c = ^rom_addr_i[1:0];

    // Word write: the three buffered bytes form the upper part, the fourth byte is the LSB.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[word_ptr] <= {byte_buf, ld_byte_i};
        end
    end

    // Fetch port: only a runnable program is visible to the core.
    always_comb begin
        rom_data_o = '0;
        if (rom_ce_i && (state == S_RUN) && (rom_addr_i[31:ADDR_W+2] == '0)) begin
            rom_data_o = mem[rom_addr_i[ADDR_W+1:2]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT_RUN ? S_RUN : S_IDLE;
            cpu_rst_o  <= ~BOOT_RUN;
            ld_ready_o <= 1'b0;
            ld_busy_o  <= 1'b0;
            ld_done_o  <= 1'b0;
            ld_err_o   <= 1'b0;
            len        <= '0;
            byte_cnt   <= '0;
            word_ptr   <= '0;
            byte_buf   <= '0;
        end else begin
            ld_done_o <= 1'b0;
            ld_err_o  <= 1'b0;
            case (state)
                S_IDLE, S_RUN: begin
                    if (ld_start_i) begin
                        if (len_ok_c) begin
                            state      <= S_LOAD;
                            len        <= ld_len_i;
                            byte_cnt   <= '0;
                            word_ptr   <= '0;
                            cpu_rst_o  <= 1'b1;
                            ld_ready_o <= 1'b1;
                            ld_busy_o  <= 1'b1;
                        end else begin
                            ld_err_o <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept_c) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        byte_buf <= {byte_buf[15:0], ld_byte_i};
                        if (byte_cnt == 2'd3) begin
                            word_ptr <= word_ptr + ADDR_W'(1);
                            if (last_word_c) begin
                                state      <= S_RELEASE;
                                ld_ready_o <= 1'b0;
                                ld_done_o  <= 1'b1;
                            end
                        end
                    end
                end
                S_RELEASE: begin
                    state     <= S_RUN;
                    cpu_rst_o <= 1'b0;
                    ld_busy_o <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
